// File: rtl/minute_hour_display.sv
// Minute/hour BCD clock with rising-edge inputs and a four-digit multiplexed 7-segment scan.
// Define TWELVE_HOUR_EN for a 12-hour count (12,01..11) with a blanked leading hour zero.
module minute_hour_display #(
    parameter int unsigned SCAN_DIV = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       min_tick,
    input  logic       min_inc,
    input  logic       hour_inc,
    output logic       day_tick,
    output logic [7:0] seg_com,
    output logic [7:0] seg_data
);

    localparam int unsigned DIV_W = 8;

`ifdef TWELVE_HOUR_EN
    localparam logic [1:0] HR_T_RST = 2'd1;
    localparam logic [3:0] HR_O_RST = 4'd2;
`else
    localparam logic [1:0] HR_T_RST = 2'd0;
    localparam logic [3:0] HR_O_RST = 4'd0;
`endif

    logic             tick_q, minc_q, hinc_q, armed;
    logic [2:0]       min_t, min_t_nx;
    logic [3:0]       min_o, min_o_nx;
    logic [1:0]       hr_t, hr_t_nx;
    logic [3:0]       hr_o, hr_o_nx;
    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       scan_idx;

    logic             tick_edge, minc_edge, hinc_edge;
    logic             min_adv, hr_adv, min_at_59, hr_at_last;
    logic [3:0]       digit;
    logic [7:0]       com_nx, data_nx;

    function automatic logic [7:0] seg_pat(input logic [3:0] d);
        case (d)
            4'd0:    seg_pat = 8'b1111_1100;
            4'd1:    seg_pat = 8'b0110_0000;
            4'd2:    seg_pat = 8'b1101_1010;
            4'd3:    seg_pat = 8'b1111_0010;
            4'd4:    seg_pat = 8'b0110_0110;
            4'd5:    seg_pat = 8'b1011_0110;
            4'd6:    seg_pat = 8'b1011_1110;
            4'd7:    seg_pat = 8'b1110_0000;
            4'd8:    seg_pat = 8'b1111_1110;
            4'd9:    seg_pat = 8'b1111_0110;
            default: seg_pat = 8'b0000_0000;
        endcase
    endfunction

    // Edge detect; armed suppresses a spurious edge for inputs already high at reset release
    always_comb begin
        tick_edge  = armed & min_tick & ~tick_q;
        minc_edge  = armed & min_inc & ~minc_q;
        hinc_edge  = armed & hour_inc & ~hinc_q;
        min_at_59  = (min_t == 3'd5) && (min_o == 4'd9);
`ifdef TWELVE_HOUR_EN
        hr_at_last = (hr_t == 2'd1) && (hr_o == 4'd1);
`else
        hr_at_last = (hr_t == 2'd2) && (hr_o == 4'd3);
`endif
        min_adv    = tick_edge | minc_edge;
        hr_adv     = hinc_edge | (tick_edge & min_at_59);
    end

    // Next BCD minute and hour values
    always_comb begin
        min_t_nx = min_t;
        min_o_nx = min_o + 4'd1;
        if (min_o == 4'd9) begin
            min_o_nx = 4'd0;
            min_t_nx = (min_t == 3'd5) ? 3'd0 : min_t + 3'd1;
        end
        hr_t_nx = hr_t;
        hr_o_nx = hr_o + 4'd1;
`ifdef TWELVE_HOUR_EN
        if ((hr_t == 2'd1) && (hr_o == 4'd2)) begin
            hr_t_nx = 2'd0;
            hr_o_nx = 4'd1;
        end else if (hr_o == 4'd9) begin
            hr_t_nx = 2'd1;
            hr_o_nx = 4'd0;
        end
`else
        if ((hr_t == 2'd2) && (hr_o == 4'd3)) begin
            hr_t_nx = 2'd0;
            hr_o_nx = 4'd0;
        end else if (hr_o == 4'd9) begin
            hr_t_nx = hr_t + 2'd1;
            hr_o_nx = 4'd0;
        end
`endif
    end

    // Digit mux for the current scan position
    always_comb begin
        com_nx = 8'hFF;
        digit  = 4'd0;
        case (scan_idx)
            2'd0: begin com_nx = 8'h7F; digit = min_o;               end
            2'd1: begin com_nx = 8'hBF; digit = 4'(min_t);          end
            2'd2: begin com_nx = 8'hDF; digit = hr_o;                end
            default: begin com_nx = 8'hEF; digit = 4'(hr_t);        end
        endcase
        data_nx = seg_pat(digit) | {7'b0, (scan_idx == 2'd2)};
`ifdef TWELVE_HOUR_EN
        if ((scan_idx == 2'd3) && (hr_t == 2'd0)) data_nx = 8'h00;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_q   <= 1'b0;
            minc_q   <= 1'b0;
            hinc_q   <= 1'b0;
            armed    <= 1'b0;
            min_t    <= 3'd0;
            min_o    <= 4'd0;
            hr_t     <= HR_T_RST;
            hr_o     <= HR_O_RST;
            day_tick <= 1'b0;
            div_cnt  <= '0;
            scan_idx <= 2'd0;
            seg_com  <= 8'hFF;
            seg_data <= 8'h00;
        end else begin
            tick_q   <= min_tick;
            minc_q   <= min_inc;
            hinc_q   <= hour_inc;
            armed    <= 1'b1;
            if (min_adv) begin
                min_t <= min_t_nx;
                min_o <= min_o_nx;
            end
            if (hr_adv) begin
                hr_t <= hr_t_nx;
                hr_o <= hr_o_nx;
            end
            day_tick <= tick_edge & min_at_59 & hr_at_last;
            if (div_cnt == DIV_W'(SCAN_DIV - 1)) begin
                div_cnt  <= '0;
                scan_idx <= scan_idx + 2'd1;
            end else begin
                div_cnt  <= div_cnt + DIV_W'(1);
            end
            seg_com  <= com_nx;
            seg_data <= data_nx;
        end
    end

endmodule

// File: tb/tb_minute_hour_display.sv
// Randomized bench for minute_hour_display against a minutes-of-day reference model.
// Build with TWELVE_HOUR_EN defined to exercise the 12-hour variant.
module tb_minute_hour_display;

`ifdef TWELVE_HOUR_EN
    localparam int NH = 12;
`else
    localparam int NH = 24;
`endif
    localparam logic [7:0] SEG [10] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66,
                                        8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6};

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       min_tick = 1'b0, min_inc = 1'b0, hour_inc = 1'b0;
    logic       day_tick;
    logic [7:0] seg_com, seg_data;

    int total = 0;
    int bad = 0;

    // Model state: minutes since the start of the day (hour index 0 = 00 or 12)
    int   m = 0;
    int   idx = 0;
    logic pt = 1'b0, pmi = 1'b0, phi = 1'b0;
    bit   first = 1'b1;
    int   day_seen = 0;

    minute_hour_display #(.SCAN_DIV(1)) dut (
        .clk(clk), .rst(rst), .min_tick(min_tick), .min_inc(min_inc),
        .hour_inc(hour_inc), .day_tick(day_tick), .seg_com(seg_com), .seg_data(seg_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %02h expected %02h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void expect_disp(input int pos, output logic [7:0] com, output logic [7:0] data);
        int hh, mm;
        hh = m / 60;
        mm = m % 60;
`ifdef TWELVE_HOUR_EN
        if (hh == 0) hh = 12;
`endif
        case (pos)
            0: begin com = 8'h7F; data = SEG[mm % 10]; end
            1: begin com = 8'hBF; data = SEG[mm / 10]; end
            2: begin com = 8'hDF; data = SEG[hh % 10] | 8'h01; end
            default: begin
                com = 8'hEF;
                data = SEG[hh / 10];
`ifdef TWELVE_HOUR_EN
                if (hh / 10 == 0) data = 8'h00;
`endif
            end
        endcase
    endfunction

    // One clock with the given input levels; called #1 after a rising edge
    task automatic step(input logic t, input logic mi, input logic hi);
        logic [7:0] ecom, edata;
        logic       eday;
        bit         te, me, he;
        int         hh, mm;
        min_tick = t; min_inc = mi; hour_inc = hi;
        @(posedge clk);
        expect_disp(idx, ecom, edata);
        te = !first && t && !pt;
        me = !first && mi && !pmi;
        he = !first && hi && !phi;
        pt = t; pmi = mi; phi = hi; first = 1'b0;
        hh = m / 60;
        mm = m % 60;
        eday = te && (m == NH * 60 - 1);
        if (he || (te && mm == 59)) hh = (hh + 1) % NH;
        if (te || me) mm = (mm + 1) % 60;
        m = hh * 60 + mm;
        idx = (idx + 1) % 4;
        #1;
        chk("seg_com", seg_com, ecom);
        chk("seg_data", seg_data, edata);
        chk("day_tick", {7'b0, day_tick}, {7'b0, eday});
        if (day_tick) day_seen++;
    endtask

    task automatic press(input logic t, input logic mi, input logic hi);
        step(t, mi, hi);
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #2;
        chk("rst_com", seg_com, 8'hFF);
        chk("rst_data", seg_data, 8'h00);
        chk("rst_day", {7'b0, day_tick}, 8'h00);
        @(posedge clk);
        #1;
        rst = 1'b1;
        m = 0; idx = 0; pt = 1'b0; pmi = 1'b0; phi = 1'b0; first = 1'b1;
    endtask

    task automatic set_time(input int h_target, input int m_target);
        for (int i = 0; i < 30 && (m / 60) != h_target; i++) press(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 70 && (m % 60) != m_target; i++) press(1'b0, 1'b1, 1'b0);
        chk("preset", 8'((m / 60) * 64 + (m % 60)), 8'(h_target * 64 + m_target));
    endtask

    initial begin
        bit found;
        @(posedge clk);
        #1;
        do_reset();

        // Idle scan after reset: 7F/FC, BF/FC, DF/FD, EF/FC (12:00 differs in 12-hour mode)
        repeat (8) step(1'b0, 1'b0, 1'b0);

        // 60 automatic ticks from the reset time roll to hour index 1
        repeat (60) press(1'b1, 1'b0, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (seg_com == 8'hDF) begin
                found = 1'b1;
                chk("h1_digit", seg_data, 8'h61);
            end
        end
        if (!found) chk("h1_scan_timeout", 8'h00, 8'h01);

        // Last minute of the day, automatic rollover pulses day_tick once
        set_time(NH - 1, 59);
        day_seen = 0;
        press(1'b1, 1'b0, 1'b0);
        repeat (6) step(1'b0, 1'b0, 1'b0);
        chk("day_count", 8'(day_seen), 8'd1);
        chk("rollover_time", 8'(m), 8'd0);

        // Manual minute wrap leaves hours alone and no day_tick
        set_time(10, 59);
        day_seen = 0;
        press(1'b0, 1'b1, 1'b0);
        repeat (4) step(1'b0, 1'b0, 1'b0);
        chk("minc_wrap_time", 8'(m / 60 * 64 + m % 60), 8'(10 * 64));
        chk("minc_wrap_day", 8'(day_seen), 8'd0);
        set_time(NH - 1, 30);
        day_seen = 0;
        press(1'b0, 1'b0, 1'b1);
        repeat (4) step(1'b0, 1'b0, 1'b0);
        chk("hinc_wrap_day", 8'(day_seen), 8'd0);

        // Coincident min_tick and min_inc at 00:05 gives a single +1
        set_time(0, 5);
        press(1'b1, 1'b1, 1'b0);
        repeat (4) step(1'b0, 1'b0, 1'b0);

        // Tick carry coinciding with hour_inc advances hours once
        set_time(3, 59);
        press(1'b1, 1'b0, 1'b1);
        repeat (4) step(1'b0, 1'b0, 1'b0);

        // Reset mid-operation with inputs held high: no edge on release
        step(1'b1, 1'b1, 1'b1);
        do_reset();
        repeat (8) step(1'b1, 1'b1, 1'b1);
        repeat (4) step(1'b0, 1'b0, 1'b0);

        // Random levels
        repeat (3000) step(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) == 0),
                           1'($urandom_range(0, 5) == 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/minute_hour_display.md
MINUTE_HOUR_DISPLAY -- requirements
Module: minute_hour_display

Interface
REQ-001 SHALL have parameter: SCAN_DIV, default 1, clk cycles per digit-scan step (legal range 1..255).
REQ-002 SHALL have port: clk  input  1  system clock; all state on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: min_tick  input  1  minute carry level from the seconds stage (clk_min_1); counted on its rising edge only.
REQ-005 SHALL have port: min_inc  input  1  manual minute-set button; counted on its rising edge only.
REQ-006 SHALL have port: hour_inc  input  1  manual hour-set button; counted on its rising edge only.
REQ-007 SHALL have port: day_tick  output  1  one-clk pulse on automatic day rollover.
REQ-008 SHALL have port: seg_com  output  8  digit select, active-low one-hot; bit7 = minute ones, bit6 = minute tens, bit5 = hour ones, bit4 = hour tens; bits 3:0 always 1.
REQ-009 SHALL have port: seg_data  output  8  segments {a,b,c,d,e,f,g,dp}, active-high.

Function
REQ-010 SHALL register min_tick, min_inc and hour_inc once and detect edges as registered-value 0 -> 1; each edge is one event.
REQ-011 SHALL hold minutes as BCD tens (0..5) and BCD ones (0..9).
REQ-012 SHALL hold hours as BCD tens (0..2) and BCD ones (0..9); 24 h range is 00..23.
REQ-013 SHALL advance minutes by exactly 1 in the cycle after a min_tick edge or a min_inc edge.
REQ-014 SHALL produce a single +1 when min_tick and min_inc edges occur in the same cycle, never +2.
REQ-015 SHALL, on a min_tick-driven 59 -> 00 minute wrap, advance hours by 1 in the same cycle.
REQ-016 SHALL, on a min_inc-driven 59 -> 00 minute wrap, leave hours unchanged.
REQ-017 SHALL advance hours by 1 on a hour_inc edge, wrapping 23 -> 00 without changing minutes and without asserting day_tick.
REQ-018 SHALL, when a min_tick carry and a hour_inc edge coincide, advance hours by 1 only.
REQ-019 SHALL assert day_tick for exactly one cycle, registered, on an automatic 23:59 -> 00:00 transition.
REQ-020 SHALL step a 2-bit scan index every SCAN_DIV clk cycles in the order 0 -> 1 -> 2 -> 3 -> 0, selecting minute ones, minute tens, hour ones and hour tens respectively.
REQ-021 SHALL register seg_com and seg_data together, so both reflect the same digit one cycle after the scan index changes.
REQ-022 SHALL encode digit segments as: 0=11111100, 1=01100000, 2=11011010, 3=11110010, 4=01100110, 5=10110110, 6=10111110, 7=11100000, 8=11111110, 9=11110110.
REQ-023 SHALL set dp (bit0) to 1 on the hour-ones digit as a separator, and to 0 on every other digit.
REQ-024 SHALL show the new count value on the next scan of the affected digit, with no glitch between digits.

Reset
REQ-025 SHALL, while rst=0, force: time 00:00 (12:00 with TWELVE_HOUR_EN), day_tick=0, scan index 0, scan divider 0, edge registers 0, seg_com=8'b1111_1111, seg_data=8'b0000_0000.
REQ-026 SHALL not detect an edge for an input already high when rst is released.
REQ-027 SHALL abandon any in-progress increment when reset is asserted mid-operation; no partial BCD state may persist.

Configuration
REQ-028 SHALL, when macro TWELVE_HOUR_EN is defined, count hours 12, 01, 02 .. 11, 12 and reset to 12:00.
REQ-029 SHALL, with TWELVE_HOUR_EN defined, pulse day_tick on the automatic 11:59 -> 12:00 transition.
REQ-030 SHALL, with TWELVE_HOUR_EN defined, blank the hour-tens digit (seg_data=0) when it is 0; with the macro undefined, the 24 h behaviour of REQ-012..019 applies.

Verification
REQ-031 SHALL cover: release reset, SCAN_DIV=1, hold inputs low -> seg_com cycles 7F, BF, DF, EF; seg_data FC, FC, FD, FC.
REQ-032 SHALL cover: 60 min_tick pulses from 00:00 -> time 01:00; hour-ones digit seg_data = 61.
REQ-033 SHALL cover: preset 23:59, one min_tick -> 00:00 and day_tick high for exactly 1 cycle.
REQ-034 SHALL cover: preset 10:59, one min_inc -> 10:00, day_tick stays 0; then hour_inc at 23:xx -> 00:xx.
REQ-035 SHALL cover: min_tick and min_inc rising in the same cycle at 00:05 -> 00:06.
REQ-036 SHALL cover: TWELVE_HOUR_EN defined, preset 11:59, one min_tick -> 12:00 with day_tick pulse; at 01:00 the hour-tens seg_data = 00.
